// File: rtl/ofm_addr_controller.sv
// OFM RAM write address generator: drains one systolic tile per start pulse and
// walks tile position across the layer (row fastest, then column block, then filter group).
module ofm_addr_controller #(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_RAM_SIZE  = 524172,
    localparam int AW = $clog2(OFM_RAM_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [8:0]    ofm_size,
    input  logic [10:0]   ofm_channel,
    output logic [AW-1:0] ofm_addr,
    output logic          write_en,
    output logic [4:0]    pixel_sel,
    output logic [4:0]    ch_sel,
    output logic          busy,
    output logic          tile_done,
    output logic          layer_done
);

    typedef enum logic [1:0] {IDLE, WRITE, TILE_END} state_t;

    state_t        state_q, state_d;
    logic [8:0]    row_q, row_d, col_q, col_d;
    logic [10:0]   chb_q, chb_d;
    logic [4:0]    px_q, px_d, ch_q, ch_d;
    logic [4:0]    vpx_q, vpx_d, vch_q, vch_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [4:0]    psel_q, psel_d, csel_q, csel_d;
    logic          we_q, we_d, tdone_q, tdone_d, ldone_q, ldone_d;

    logic [31:0]   plane, tile_base;
    logic [8:0]    diff_px;
    logic [10:0]   diff_ch;
    logic          last_row, last_col, last_grp;

    assign plane     = 32'(ofm_size) * 32'(ofm_size);
    assign tile_base = 32'(chb_q) * plane + 32'(row_q) * 32'(ofm_size) + 32'(col_q);
    assign diff_px   = ofm_size - col_q;
    assign diff_ch   = ofm_channel - chb_q;
    assign last_row  = (row_q == ofm_size - 9'd1);
    assign last_col  = ({1'b0, col_q} + 10'(SYSTOLIC_SIZE)) >= {1'b0, ofm_size};
    assign last_grp  = ({1'b0, chb_q} + 12'(SYSTOLIC_SIZE)) >= {1'b0, ofm_channel};

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        chb_d   = chb_q;
        px_d    = px_q;
        ch_d    = ch_q;
        vpx_d   = vpx_q;
        vch_d   = vch_q;
        addr_d  = addr_q;
        psel_d  = psel_q;
        csel_d  = csel_q;
        we_d    = 1'b0;
        tdone_d = 1'b0;
        ldone_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WRITE;
                    px_d    = 5'd0;
                    ch_d    = 5'd0;
                    vpx_d   = (diff_px > 9'(SYSTOLIC_SIZE))  ? 5'(SYSTOLIC_SIZE) : diff_px[4:0];
                    vch_d   = (diff_ch > 11'(SYSTOLIC_SIZE)) ? 5'(SYSTOLIC_SIZE) : diff_ch[4:0];
                end
            end
            WRITE: begin
                if (px_q < vpx_q - 5'd1) begin
                    px_d = px_q + 5'd1;
                end else if (ch_q < vch_q - 5'd1) begin
                    px_d = 5'd0;
                    ch_d = ch_q + 5'd1;
                end else begin
                    state_d = TILE_END;
                    tdone_d = 1'b1;
                    ldone_d = last_row && last_col && last_grp;
                end
            end
            TILE_END: begin
                state_d = IDLE;
                if (!last_row) begin
                    row_d = row_q + 9'd1;
                end else begin
                    row_d = 9'd0;
                    if (!last_col) begin
                        col_d = col_q + 9'(SYSTOLIC_SIZE);
                    end else begin
                        col_d = 9'd0;
                        chb_d = last_grp ? 11'd0 : chb_q + 11'(SYSTOLIC_SIZE);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next-state values so a write appears the cycle after its edge.
        if (state_d == WRITE) begin
            we_d   = 1'b1;
            addr_d = AW'(tile_base + 32'(ch_d) * plane + 32'(px_d));
            psel_d = px_d;
            csel_d = ch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            chb_q   <= '0;
            px_q    <= '0;
            ch_q    <= '0;
            vpx_q   <= '0;
            vch_q   <= '0;
            addr_q  <= '0;
            psel_q  <= '0;
            csel_q  <= '0;
            we_q    <= 1'b0;
            tdone_q <= 1'b0;
            ldone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            chb_q   <= chb_d;
            px_q    <= px_d;
            ch_q    <= ch_d;
            vpx_q   <= vpx_d;
            vch_q   <= vch_d;
            addr_q  <= addr_d;
            psel_q  <= psel_d;
            csel_q  <= csel_d;
            we_q    <= we_d;
            tdone_q <= tdone_d;
            ldone_q <= ldone_d;
        end
    end

    assign ofm_addr   = addr_q;
    assign write_en   = we_q;
    assign pixel_sel  = psel_q;
    assign ch_sel     = csel_q;
    assign busy       = (state_q != IDLE);
    assign tile_done  = tdone_q;
    assign layer_done = ldone_q;

endmodule

// File: tb/tb_ofm_addr_controller.sv
// Scoreboard bench for ofm_addr_controller: a tile-order model pushes expected
// writes at start, a negedge monitor pops and compares them as the DUT writes.
module tb_ofm_addr_controller;

    localparam int SS = 16;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [8:0]    ofm_size;
    logic [10:0]   ofm_channel;
    logic [AW-1:0] ofm_addr;
    logic          write_en;
    logic [4:0]    pixel_sel;
    logic [4:0]    ch_sel;
    logic          busy;
    logic          tile_done;
    logic          layer_done;

    ofm_addr_controller #(.SYSTOLIC_SIZE(SS), .OFM_RAM_SIZE(524172)) dut (
        .clk(clk), .rst(rst), .start(start), .ofm_size(ofm_size), .ofm_channel(ofm_channel),
        .ofm_addr(ofm_addr), .write_en(write_en), .pixel_sel(pixel_sel), .ch_sel(ch_sel),
        .busy(busy), .tile_done(tile_done), .layer_done(layer_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  px;
        logic [4:0]  ch;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  tiles_seen = 0;
    logic exp_layer = 1'b0;
    int  m_row = 0, m_col = 0, m_chb = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (write_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(write_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("ofm_addr", 32'(ofm_addr), e.addr);
                chk("pixel_sel", 32'(pixel_sel), 32'(e.px));
                chk("ch_sel", 32'(ch_sel), 32'(e.ch));
            end
        end
        if (tile_done) begin
            tiles_seen++;
            chk("writes_left_at_tile_done", exp_q.size(), 32'd0);
            chk("layer_done", 32'(layer_done), 32'(exp_layer));
            chk("we_at_tile_done", 32'(write_en), 32'd0);
        end else if (layer_done) begin
            chk("layer_done_without_tile_done", 32'(layer_done), 32'd0);
        end
    end

    task automatic push_tile(output int n);
        int size, chn, vpx, vch;
        wr_t e;
        size = int'(ofm_size);
        chn  = int'(ofm_channel);
        vpx  = (size - m_col > SS) ? SS : size - m_col;
        vch  = (chn - m_chb > SS) ? SS : chn - m_chb;
        for (int c = 0; c < vch; c++) begin
            for (int p = 0; p < vpx; p++) begin
                e.addr = 32'((m_chb + c) * size * size + m_row * size + m_col + p);
                e.px   = 5'(p);
                e.ch   = 5'(c);
                exp_q.push_back(e);
            end
        end
        n = vpx * vch;
        exp_layer = (m_row == size - 1) && (m_col + SS >= size) && (m_chb + SS >= chn);
    endtask

    task automatic advance_model();
        int size, chn;
        size = int'(ofm_size);
        chn  = int'(ofm_channel);
        if (m_row < size - 1) begin
            m_row++;
        end else begin
            m_row = 0;
            if (m_col + SS < size) begin
                m_col += SS;
            end else begin
                m_col = 0;
                if (m_chb + SS < chn) m_chb += SS;
                else m_chb = 0;
            end
        end
    endtask

    task automatic run_tile(input bit inject);
        int n;
        bit done;
        done = 1'b0;
        push_tile(n);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= n + 6; k++) begin
            @(negedge clk);
            start = inject && (k == 2 || k == n + 1);
            if (tile_done) begin
                chk("tile_done_latency", k, n + 1);
                done = 1'b1;
                break;
            end
            chk("busy_in_tile", 32'(busy), 32'd1);
            if (k <= n) chk("we_in_tile", 32'(write_en), 32'd1);
        end
        if (!done) chk("tile_done_timeout", 32'(done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_tile", 32'(busy), 32'd0);
        chk("we_after_tile", 32'(write_en), 32'd0);
        advance_model();
    endtask

    task automatic run_layer(input int size, input int chn, input int tiles, input bit inject);
        int base;
        ofm_size    = 9'(size);
        ofm_channel = 11'(chn);
        base = tiles_seen;
        for (int t = 0; t < tiles; t++) run_tile(inject && t < 2);
        repeat (3) @(negedge clk);
        chk("tiles_in_layer", tiles_seen - base, tiles);
        chk("model_wrapped", m_row + m_col + m_chb, 0);
    endtask

    task automatic reset_mid_tile();
        int n;
        push_tile(n);
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("we_before_rst", 32'(write_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_we", 32'(write_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(ofm_addr), 32'd0);
        chk("rst_psel", 32'(pixel_sel), 32'd0);
        chk("rst_csel", 32'(ch_sel), 32'd0);
        chk("rst_tile_done", 32'(tile_done), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        m_chb = 0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ofm_size = 9'd4;
        ofm_channel = 11'd2;
        repeat (3) @(negedge clk);
        chk("reset_we", 32'(write_en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(ofm_addr), 32'd0);
        chk("reset_tile_done", 32'(tile_done), 32'd0);
        chk("reset_layer_done", 32'(layer_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_layer(4, 2, 4, 1'b0);
        run_layer(4, 2, 4, 1'b1);
        run_layer(20, 16, 40, 1'b0);
        run_layer(2, 20, 4, 1'b0);

        ofm_size = 9'd4;
        ofm_channel = 11'd2;
        run_tile(1'b0);
        reset_mid_tile();
        run_layer(4, 2, 4, 1'b0);

        run_layer(1, 1, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
